fetch_queue: RTL and testbench

Parametrised fetch-to-decode buffer that replaces the single-entry IF/ID stage register with a DEPTH-entry FIFO under a valid/ready handshake. Each entry carries the fetched instruction's pc, next pc, instruction word and predicted target. A branch-resolution flush empties the queue in one cycle. When empty, the block presents a bubble (FlushInst, zero pc/npc/pred) to decode. It sits between the fetch unit and the decoder, decoupling instruction-memory latency from decode stalls.

---
 rtl/fetch_queue_pkg.sv | 10 +
 rtl/fetch_queue_mem.sv | 25 ++
 rtl/fetch_queue.sv | 99 +++++++++
 tb/tb_fetch_queue.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch-to-decode queue: bus widths and the bubble instruction.
package fetch_queue_pkg;

    localparam int XLEN_DEFAULT = 32;   // InstAddrBus width
    localparam int ILEN_DEFAULT = 32;   // InstBus width

    // addi x0, x0, 0: what decode sees whenever there is nothing to issue
    localparam logic [31:0] FLUSH_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: one write port, asynchronous read, contents never reset.
module fetch_queue_mem #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// DEPTH-entry fetch-to-decode FIFO with single-cycle flush and bubble output when empty.
// Optional same-cycle empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int ILEN  = ILEN_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_npc,
    input  logic [XLEN-1:0]            in_pred,
    input  logic [ILEN-1:0]            in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_npc,
    output logic [XLEN-1:0]            out_pred,
    output logic [ILEN-1:0]            out_inst,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = 3*XLEN + ILEN;

    logic [PTR_W-1:0]   wp, rp;
    logic [CNT_W-1:0]   count_q;
    logic [ENTRY_W-1:0] wdata, rdata, head;
    logic               empty, full, push, pop, bypass;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign wdata = {in_pc, in_npc, in_pred, in_inst};

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    // Handshake: a side transfers on an rdy edge where its valid and ready are both high and
    // flush is low; valid never depends on ready, and in_ready comes from count alone.
    assign in_ready  = !full;
    assign out_valid = !empty || bypass;

    // A bypassed entry that decode takes in the same cycle never touches storage.
    assign pop  = rdy && !flush && !empty && out_ready;
    assign push = rdy && !flush && in_valid && !full && !(bypass && out_ready);

    assign head = bypass ? wdata : rdata;
    assign {out_pc, out_npc, out_pred, out_inst} =
        out_valid ? head : {{(3*XLEN){1'b0}}, ILEN'(FLUSH_INST)};
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else if (rdy && flush) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wp <= wp + PTR_W'(1);
            end
            if (pop) begin
                rp <= rp + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    fetch_queue_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wp),
        .wdata (wdata),
        .raddr (rp),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_queue;

    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int EW    = 3*XLEN + ILEN;
    localparam logic [ILEN-1:0] BUBBLE_INST = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rdy = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic            in_ready, out_valid;
    logic [XLEN-1:0] in_pc = '0, in_npc = '0, in_pred = '0;
    logic [ILEN-1:0] in_inst = '0;
    logic [XLEN-1:0] out_pc, out_npc, out_pred;
    logic [ILEN-1:0] out_inst;
    logic [CW-1:0]   count;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_npc    (in_npc),
        .in_pred   (in_pred),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_npc   (out_npc),
        .out_pred  (out_pred),
        .out_inst  (out_inst),
        .count     (count)
    );

    // ---------------- reference model ----------------
    // Expected decode-side view: {valid, pc, npc, pred, inst}.
    function automatic logic [EW:0] model_out();
        if (exp_q.size() != 0) return {1'b1, exp_q[0]};
        if (BYPASS && in_valid && !flush) return {1'b1, in_pc, in_npc, in_pred, in_inst};
        return {1'b0, {(3*XLEN){1'b0}}, BUBBLE_INST};
    endfunction

    // Apply the queue rules for the current inputs, then advance one clock.
    task automatic tick();
        logic [EW:0] o;
        bit acc;
        bit take;
        o = model_out();
        if (rst) begin
            exp_q.delete();
        end else if (rdy) begin
            if (flush) begin
                exp_q.delete();
            end else if (exp_q.size() == 0 && o[EW] && out_ready) begin
                // bypassed entry consumed directly by decode
            end else begin
                acc  = in_valid && (exp_q.size() < DEPTH);
                take = o[EW] && out_ready;
                if (take) void'(exp_q.pop_front());
                if (acc) exp_q.push_back({in_pc, in_npc, in_pred, in_inst});
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                         input logic [XLEN-1:0] pc);
        rdy       = r;
        flush     = f;
        in_valid  = iv;
        out_ready = ordy;
        in_pc     = pc;
        in_npc    = pc + 32'd4;
        in_pred   = $urandom;
        in_inst   = $urandom;
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 2*DEPTH && exp_q.size() != 0; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (count !== CW'(0)) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_inst !== BUBBLE_INST) begin errors++; $display("FAIL reset_out_inst got %h exp %h", out_inst, BUBBLE_INST); end
        checks++; if (out_pc !== '0) begin errors++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h100 + 32'(4*i));
            tick();
        end
        checks++; if (count !== CW'(4)) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b exp 0", in_ready); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h110);
        tick();
        checks++; if (count !== CW'(4)) begin errors++; $display("FAIL fill_fifth_count got %0d exp 4", count); end
        checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL fill_head_pc got %h exp 00000100", out_pc); end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4*i)) begin
                errors++;
                $display("FAIL fill_drain_%0d got valid=%b pc=%h exp valid=1 pc=%h", i, out_valid, out_pc, 32'h100 + 32'(4*i));
            end
            tick();
        end
        checks++; if (count !== CW'(0)) begin errors++; $display("FAIL fill_drained_count got %0d exp 0", count); end
    endtask

    task automatic test_stream();
        logic [EW:0] o;
        int nxt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h200 + 32'(4*i));
            o = model_out();
            if (o[EW]) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'h200 + 32'(4*nxt)) begin
                    errors++;
                    $display("FAIL stream_order_%0d got valid=%b pc=%h exp pc=%h", i, out_valid, out_pc, 32'h200 + 32'(4*nxt));
                end
                nxt++;
            end
            tick();
            checks++;
            if (count !== CW'(exp_q.size())) begin
                errors++;
                $display("FAIL stream_count_%0d got %0d exp %0d", i, count, exp_q.size());
            end
        end
        while (exp_q.size() != 0 && nxt < 12) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
            checks++;
            if (out_pc !== 32'h200 + 32'(4*nxt)) begin
                errors++;
                $display("FAIL stream_tail got pc=%h exp pc=%h", out_pc, 32'h200 + 32'(4*nxt));
            end
            nxt++;
            tick();
        end
        checks++; if (nxt != 10) begin errors++; $display("FAIL stream_total got %0d exp 10", nxt); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h280 + 32'(4*i));
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h300);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
        checks++; if (count !== CW'(0)) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
        checks++; if (out_inst !== BUBBLE_INST) begin errors++; $display("FAIL flush_out_inst got %h exp %h", out_inst, BUBBLE_INST); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
            checks++;
            if (out_valid !== 1'b0 || out_pc === 32'h300) begin
                errors++;
                $display("FAIL flush_leak_%0d got valid=%b pc=%h exp valid=0", i, out_valid, out_pc);
            end
            tick();
        end
    endtask

    task automatic test_rdy_freeze();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h500 + 32'(4*i));
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            checks++;
            if (count !== CW'(2) || out_pc !== 32'h500) begin
                errors++;
                $display("FAIL freeze_%0d got count=%0d pc=%h exp count=2 pc=00000500", i, count, out_pc);
            end
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (count !== CW'(2)) begin errors++; $display("FAIL freeze_after got %0d exp 2", count); end
        drain();
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h400);
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h400) begin
            errors++;
            $display("FAIL bypass_same_cycle got valid=%b pc=%h exp valid=1 pc=00000400", out_valid, out_pc);
        end
        tick();
        checks++; if (count !== CW'(0)) begin errors++; $display("FAIL bypass_count got %0d exp 0", count); end
`else
        checks++;
        if (out_valid !== 1'b0 || out_pc !== '0) begin
            errors++;
            $display("FAIL nobypass_bubble got valid=%b pc=%h exp valid=0 pc=0", out_valid, out_pc);
        end
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (count !== CW'(1) || out_pc !== 32'h400) begin
            errors++;
            $display("FAIL nobypass_next got count=%0d pc=%h exp count=1 pc=00000400", count, out_pc);
        end
`endif
        drain();
    endtask

    task automatic test_random();
        logic [EW:0] o;
        logic [EW:0] obs;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), $urandom);
            o   = model_out();
            obs = {out_valid, out_pc, out_npc, out_pred, out_inst};
            checks++;
            if (obs !== o) begin
                errors++;
                $display("FAIL random_out_%0d got %h exp %h", i, obs, o);
            end
            checks++;
            if (in_ready !== (exp_q.size() != DEPTH) || count !== CW'(exp_q.size())) begin
                errors++;
                $display("FAIL random_occ_%0d got in_ready=%b count=%0d exp count=%0d", i, in_ready, count, exp_q.size());
            end
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_flush();
        test_rdy_freeze();
        test_bypass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
